// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 640x480@60 timing constants and a range helper
package vga_pkg;

   localparam int H_VISIBLE = 640;
   localparam int H_FP      = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BP      = 48;
   localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

   localparam int V_VISIBLE = 480;
   localparam int V_FP      = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BP      = 33;
   localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

   localparam int CNT_W     = 10;

   function automatic logic in_span(input logic [CNT_W-1:0] v,
                                    input logic [CNT_W-1:0] lo,
                                    input logic [CNT_W-1:0] hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/wrap_counter.sv
// rtl/wrap_counter.sv - modulo-N counter with sync reset, enable and wrap flag
module wrap_counter #(
   parameter int N = 800,
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   output logic [W-1:0] value,
   output logic [W-1:0] next_value,
   output logic         wrap
);

   localparam logic [W-1:0] LAST = W'(N - 1);

   // next_value is exported so the parent can register decodes of it in lockstep
   always_comb begin
      wrap = en && (value == LAST);
      if (reset)
         next_value = '0;
      else if (wrap)
         next_value = '0;
      else if (en)
         next_value = value + 1'b1;
      else
         next_value = value;
   end

   always_ff @(posedge clk) begin
      if (reset)
         value <= '0;
      else
         value <= next_value;
   end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster counters with registered sync/blank/strobe outputs
module vga_timing_gen #(
   parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
   parameter int H_TOTAL   = vga_pkg::H_TOTAL,
   parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
   parameter int V_TOTAL   = vga_pkg::V_TOTAL,
   parameter int H_FP      = vga_pkg::H_FP,
   parameter int H_SYNC    = vga_pkg::H_SYNC,
   parameter int V_FP      = vga_pkg::V_FP,
   parameter int V_SYNC    = vga_pkg::V_SYNC
) (
   input  logic       vga_clk,
   input  logic       reset,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic       hs,
   output logic       vs,
   output logic       blank,
   output logic       line_start,
   output logic       frame_start,
   output logic [7:0] frame_count
);

   import vga_pkg::in_span;

   localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC - 1);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);

   logic [9:0] x_next;
   logic [9:0] y_next;
   logic       h_wrap;
   logic       v_wrap;

   wrap_counter #(.N(H_TOTAL), .W(10)) u_hcnt (
      .clk        (vga_clk),
      .reset      (reset),
      .en         (1'b1),
      .value      (DrawX),
      .next_value (x_next),
      .wrap       (h_wrap)
   );

   wrap_counter #(.N(V_TOTAL), .W(10)) u_vcnt (
      .clk        (vga_clk),
      .reset      (reset),
      .en         (h_wrap),
      .value      (DrawY),
      .next_value (y_next),
      .wrap       (v_wrap)
   );

   // Decoding the next counter values keeps every flag aligned with DrawX/DrawY.
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         hs          <= 1'b1;
         vs          <= 1'b1;
         blank       <= 1'b1;
         line_start  <= 1'b1;
         frame_start <= 1'b1;
         frame_count <= 8'd0;
      end else begin
         hs          <= !in_span(x_next, HS_START, HS_END);
         vs          <= !in_span(y_next, VS_START, VS_END);
         blank       <= (x_next < H_VIS) && (y_next < V_VIS);
         line_start  <= (x_next == 10'd0);
         frame_start <= (x_next == 10'd0) && (y_next == 10'd0);
         if (v_wrap)
            frame_count <= frame_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench: full-size timing plus a shrunken raster for frame-level runs
module tb_vga_timing_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_f, rst_s;
   logic [9:0] x_f, y_f, x_s, y_s;
   logic       hs_f, vs_f, bl_f, ls_f, fs_f;
   logic       hs_s, vs_s, bl_s, ls_s, fs_s;
   logic [7:0] fc_f, fc_s;

   vga_timing_gen dut_f (
      .vga_clk(clk), .reset(rst_f), .DrawX(x_f), .DrawY(y_f), .hs(hs_f), .vs(vs_f),
      .blank(bl_f), .line_start(ls_f), .frame_start(fs_f), .frame_count(fc_f)
   );

   // 16 x 12 raster: hs low at x 10..12, vs low at y 7..8, 192 cycles per frame
   vga_timing_gen #(
      .H_VISIBLE(8), .H_TOTAL(16), .V_VISIBLE(6), .V_TOTAL(12),
      .H_FP(2), .H_SYNC(3), .V_FP(1), .V_SYNC(2)
   ) dut_s (
      .vga_clk(clk), .reset(rst_s), .DrawX(x_s), .DrawY(y_s), .hs(hs_s), .vs(vs_s),
      .blank(bl_s), .line_start(ls_s), .frame_start(fs_s), .frame_count(fc_s)
   );

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       hs;
      logic       vs;
      logic       blank;
      logic       ls;
      logic       fs;
      logic [7:0] fc;
   } exp_t;

   exp_t q_f[$];
   exp_t q_s[$];
   exp_t e_f, e_s, g_f, g_s;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   fx, fy, ffc, sx, sy, sfc;

   function automatic exp_t mk(int x, int y, int fc, int hv, int vv,
                               int hs0, int hs1, int vs0, int vs1);
      exp_t e;
      e.x     = 10'(x);
      e.y     = 10'(y);
      e.fc    = 8'(fc);
      e.hs    = !(x >= hs0 && x <= hs1);
      e.vs    = !(y >= vs0 && y <= vs1);
      e.blank = (x < hv) && (y < vv);
      e.ls    = (x == 0);
      e.fs    = (x == 0) && (y == 0);
      return e;
   endfunction

   task automatic advance(inout int x, inout int y, inout int fc, input int ht, input int vt);
      if (x == ht - 1) begin
         x = 0;
         if (y == vt - 1) begin
            y  = 0;
            fc = (fc + 1) % 256;
         end else begin
            y = y + 1;
         end
      end else begin
         x = x + 1;
      end
   endtask

   task automatic tick();
      if (rst_f) begin fx = 0; fy = 0; ffc = 0; end
      else advance(fx, fy, ffc, 800, 525);
      if (rst_s) begin sx = 0; sy = 0; sfc = 0; end
      else advance(sx, sy, sfc, 16, 12);
      q_f.push_back(mk(fx, fy, ffc, 640, 480, 656, 751, 490, 491));
      q_s.push_back(mk(sx, sy, sfc, 8, 6, 10, 12, 7, 8));
      @(posedge clk);
      @(negedge clk);
   endtask

   always begin
      @(posedge clk);
      #1;
      if (q_f.size() > 0) begin
         e_f = q_f.pop_front();
         g_f = {x_f, y_f, hs_f, vs_f, bl_f, ls_f, fs_f, fc_f};
         n_tests++;
         if (g_f !== e_f) begin
            n_fail++;
            $display("FAIL sb_full got x=%0d y=%0d hs/vs/bl/ls/fs=%b%b%b%b%b fc=%0d want x=%0d y=%0d %b%b%b%b%b fc=%0d",
                     g_f.x, g_f.y, g_f.hs, g_f.vs, g_f.blank, g_f.ls, g_f.fs, g_f.fc,
                     e_f.x, e_f.y, e_f.hs, e_f.vs, e_f.blank, e_f.ls, e_f.fs, e_f.fc);
         end
      end
      if (q_s.size() > 0) begin
         e_s = q_s.pop_front();
         g_s = {x_s, y_s, hs_s, vs_s, bl_s, ls_s, fs_s, fc_s};
         n_tests++;
         if (g_s !== e_s) begin
            n_fail++;
            $display("FAIL sb_small got x=%0d y=%0d hs/vs/bl/ls/fs=%b%b%b%b%b fc=%0d want x=%0d y=%0d %b%b%b%b%b fc=%0d",
                     g_s.x, g_s.y, g_s.hs, g_s.vs, g_s.blank, g_s.ls, g_s.fs, g_s.fc,
                     e_s.x, e_s.y, e_s.hs, e_s.vs, e_s.blank, e_s.ls, e_s.fs, e_s.fc);
         end
      end
   end

   task automatic test_reset();
      rst_f = 1'b1;
      rst_s = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++;
         if ({x_f, y_f, hs_f, vs_f, bl_f, ls_f, fs_f, fc_f} !== {10'd0, 10'd0, 5'b11111, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_full cyc %0d got x=%0d y=%0d flags=%b%b%b%b%b fc=%0d want 0 0 11111 0",
                     i, x_f, y_f, hs_f, vs_f, bl_f, ls_f, fs_f, fc_f);
         end
         n_tests++;
         if ({x_s, y_s, hs_s, vs_s, bl_s, ls_s, fs_s, fc_s} !== {10'd0, 10'd0, 5'b11111, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_small cyc %0d got x=%0d y=%0d flags=%b%b%b%b%b fc=%0d want 0 0 11111 0",
                     i, x_s, y_s, hs_s, vs_s, bl_s, ls_s, fs_s, fc_s);
         end
      end
      rst_f = 1'b0;
      rst_s = 1'b0;
      for (int i = 1; i <= 2; i++) begin
         tick();
         n_tests++;
         if (x_f !== 10'(i) || y_f !== 10'd0 || bl_f !== 1'b1 || hs_f !== 1'b1 || vs_f !== 1'b1 || fc_f !== 8'd0) begin
            n_fail++;
            $display("FAIL release_count got x=%0d y=%0d bl=%b hs=%b vs=%b fc=%0d want x=%0d y=0 1 1 1 0",
                     x_f, y_f, bl_f, hs_f, vs_f, fc_f, i);
         end
      end
   endtask

   task automatic test_line();
      int t = 0;
      int hs_low = 0, hs_first = -1, bl_low = 0, bl_first = -1, ls_cnt = 0;
      while (x_f !== 10'd0 && t < 1000) begin tick(); t++; end
      n_tests++;
      if (x_f !== 10'd0) begin n_fail++; $display("FAIL line_sync_timeout got x=%0d want 0", x_f); end
      for (int i = 0; i < 800; i++) begin
         tick();
         if (hs_f === 1'b0) begin if (hs_first < 0) hs_first = int'(x_f); hs_low++; end
         if (bl_f === 1'b0) begin if (bl_first < 0) bl_first = int'(x_f); bl_low++; end
         if (ls_f === 1'b1) ls_cnt++;
      end
      n_tests++;
      if (hs_low != 96 || hs_first != 656) begin
         n_fail++;
         $display("FAIL hs_pulse got len=%0d start=%0d want 96 656", hs_low, hs_first);
      end
      n_tests++;
      if (bl_low != 160 || bl_first != 640) begin
         n_fail++;
         $display("FAIL blank_window got len=%0d start=%0d want 160 640", bl_low, bl_first);
      end
      n_tests++;
      if (ls_cnt != 1 || x_f !== 10'd0 || ls_f !== 1'b1) begin
         n_fail++;
         $display("FAIL line_period got pulses=%0d x=%0d ls=%b want 1 0 1", ls_cnt, x_f, ls_f);
      end
   endtask

   task automatic test_frame();
      int t = 0;
      int vs_low = 0, vs_x = -1, vs_y = -1, fs_cnt = 0;
      logic [7:0] fc0;
      while (!(x_s === 10'd0 && y_s === 10'd0) && t < 400) begin tick(); t++; end
      n_tests++;
      if (!(x_s === 10'd0 && y_s === 10'd0)) begin n_fail++; $display("FAIL frame_sync_timeout got x=%0d y=%0d want 0 0", x_s, y_s); end
      fc0 = fc_s;
      for (int i = 0; i < 192; i++) begin
         tick();
         if (vs_s === 1'b0) begin
            if (vs_x < 0) begin vs_x = int'(x_s); vs_y = int'(y_s); end
            vs_low++;
         end
         if (fs_s === 1'b1) fs_cnt++;
      end
      n_tests++;
      if (vs_low != 32 || vs_x != 0 || vs_y != 7) begin
         n_fail++;
         $display("FAIL vs_pulse got len=%0d start=(%0d,%0d) want 32 (0,7)", vs_low, vs_x, vs_y);
      end
      n_tests++;
      if (fs_cnt != 1 || fs_s !== 1'b1 || fc_s !== 8'(fc0 + 8'd1)) begin
         n_fail++;
         $display("FAIL frame_period got pulses=%0d fs=%b fc=%0d want 1 1 %0d", fs_cnt, fs_s, fc_s, 8'(fc0 + 8'd1));
      end
   endtask

   task automatic test_boundary();
      int t = 0;
      while (!(x_s === 10'd15 && y_s === 10'd11) && t < 400) begin tick(); t++; end
      tick();
      n_tests++;
      if ({x_s, y_s, fs_s, ls_s, bl_s} !== {10'd0, 10'd0, 3'b111}) begin
         n_fail++;
         $display("FAIL frame_boundary got x=%0d y=%0d fs/ls/bl=%b%b%b want 0 0 111", x_s, y_s, fs_s, ls_s, bl_s);
      end
      t = 0;
      while (x_s !== 10'd7 && t < 40) begin tick(); t++; end
      n_tests++;
      if (bl_s !== 1'b1) begin n_fail++; $display("FAIL blank_last_small got %b want 1", bl_s); end
      tick();
      n_tests++;
      if (bl_s !== 1'b0 || x_s !== 10'd8) begin n_fail++; $display("FAIL blank_drop_small got bl=%b x=%0d want 0 8", bl_s, x_s); end
      t = 0;
      while (x_f !== 10'd639 && t < 900) begin tick(); t++; end
      n_tests++;
      if (bl_f !== 1'b1) begin n_fail++; $display("FAIL blank_last_full got %b want 1", bl_f); end
      tick();
      n_tests++;
      if (bl_f !== 1'b0 || x_f !== 10'd640) begin n_fail++; $display("FAIL blank_drop_full got bl=%b x=%0d want 0 640", bl_f, x_f); end
   endtask

   task automatic test_mid_reset();
      int t = 0;
      logic vs_seen = 1'b0;
      while (!(x_s === 10'd11 && y_s === 10'd8) && t < 400) begin tick(); t++; end
      n_tests++;
      if (hs_s !== 1'b0 || vs_s !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_sync_state got hs=%b vs=%b at x=%0d y=%0d want 0 0", hs_s, vs_s, x_s, y_s);
      end
      rst_s = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_tests++;
         if ({x_s, y_s, hs_s, vs_s, bl_s, ls_s, fs_s, fc_s} !== {10'd0, 10'd0, 5'b11111, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_hold cyc %0d got x=%0d y=%0d flags=%b%b%b%b%b fc=%0d want 0 0 11111 0",
                     i, x_s, y_s, hs_s, vs_s, bl_s, ls_s, fs_s, fc_s);
         end
      end
      rst_s = 1'b0;
      t = 0;
      while (hs_s !== 1'b0 && t < 100) begin
         tick();
         t++;
         if (vs_s === 1'b0) vs_seen = 1'b1;
      end
      n_tests++;
      if (hs_s !== 1'b0 || x_s !== 10'd10 || y_s !== 10'd0 || vs_seen) begin
         n_fail++;
         $display("FAIL resume_hs got hs=%b x=%0d y=%0d vs_seen=%b want 0 10 0 0", hs_s, x_s, y_s, vs_seen);
      end
   endtask

   task automatic test_fc_wrap();
      int t = 0;
      logic [7:0] prev;
      logic wrapped = 1'b0;
      while (fs_s !== 1'b1 && t < 400) begin tick(); t++; end
      n_tests++;
      if (fs_s !== 1'b1 || fc_s !== 8'd1) begin
         n_fail++;
         $display("FAIL first_frame_count got fs=%b fc=%0d want 1 1", fs_s, fc_s);
      end
      t = 0;
      prev = fc_s;
      while (!wrapped && t < 256 * 192 + 400) begin
         tick();
         t++;
         if (prev === 8'd255 && fc_s === 8'd0) wrapped = 1'b1;
         prev = fc_s;
      end
      n_tests++;
      if (!wrapped || fs_s !== 1'b1) begin
         n_fail++;
         $display("FAIL fc_wrap got wrapped=%b fc=%0d fs=%b want 1 0 1", wrapped, fc_s, fs_s);
      end
   endtask

   initial begin
      rst_f = 1'b1;
      rst_s = 1'b1;
      test_reset();
      test_line();
      test_frame();
      test_boundary();
      test_mid_reset();
      test_fc_wrap();
      @(posedge clk);
      #2;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
